// File: rtl/program_loader_pkg.sv
// ============================================================================
// Module : program_loader_pkg
// Brief  : Shared constants, state encodings and helpers for the program loader
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package program_loader_pkg;

    localparam int LOADER_MEM_WORDS_DEFAULT = 64;

    localparam logic [2:0] LOADER_IDLE  = 3'd0;
    localparam logic [2:0] LOADER_LEN0  = 3'd1;
    localparam logic [2:0] LOADER_LEN1  = 3'd2;
    localparam logic [2:0] LOADER_DATA  = 3'd3;
    localparam logic [2:0] LOADER_DONE  = 3'd4;
    localparam logic [2:0] LOADER_ERROR = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = LOADER_IDLE,
        ST_LEN0  = LOADER_LEN0,
        ST_LEN1  = LOADER_LEN1,
        ST_DATA  = LOADER_DATA,
        ST_DONE  = LOADER_DONE,
        ST_ERROR = LOADER_ERROR
    } loader_state_e;

    function automatic logic count_in_range(input logic [15:0] count, input logic [15:0] max_words);
        return (count != 16'd0) && (count <= max_words);
    endfunction

endpackage

`default_nettype wire

// File: rtl/program_loader_if.sv
// ============================================================================
// Module : program_loader_if
// Brief  : Host byte link, program-memory write port and status of the loader
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface program_loader_if #(
    parameter int ADDR_WIDTH = 6
) ();
    logic                  start;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  core_reset;
    logic                  done;
    logic                  error;

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata, core_reset, done, error
    );

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata, core_reset, done, error
    );
endinterface

`default_nettype wire

// File: rtl/program_loader_byte_to_word_assembler.sv
// ============================================================================
// Module : program_loader_byte_to_word_assembler
// Brief  : Packs four bytes little-endian into a 32-bit word, pulsing on the 4th
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module program_loader_byte_to_word_assembler (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        clear_i,
    input  wire logic        push_i,
    input  wire logic [7:0]  byte_i,
    output logic             word_ready_o,
    output logic [31:0]      word_o
);
    logic [1:0]  lane_q;
    logic [31:0] buf_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            lane_q <= 2'd0;
            buf_q  <= 32'd0;
        end else if (push_i) begin
            case (lane_q)
                2'd0:    buf_q[7:0]   <= byte_i;
                2'd1:    buf_q[15:8]  <= byte_i;
                2'd2:    buf_q[23:16] <= byte_i;
                default: buf_q[31:24] <= byte_i;
            endcase
            lane_q <= lane_q + 2'd1;
        end
    end

    // The 4th byte bypasses the buffer so the word is available on its accept edge.
    assign word_ready_o = push_i && !clear_i && (lane_q == 2'd3);
    assign word_o       = {byte_i, buf_q[23:0]};
endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module : program_loader
// Brief  : Loads a length-prefixed byte stream into program memory; holds core in reset
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module program_loader
    import program_loader_pkg::*;
#(
    parameter int PROGRAM_MEMORY_SIZE_WORDS = LOADER_MEM_WORDS_DEFAULT,
    parameter int ADDR_WIDTH                = 6
) (
    input  wire logic        clk,
    input  wire logic        reset,
    program_loader_if.slave  bus
);
    loader_state_e         state_q;
    logic [15:0]           count_q;
    logic [ADDR_WIDTH:0]   idx_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic                  core_reset_q;

    logic        w_ready;
    logic        w_xfer;
    logic        w_start_ok;
    logic        w_push;
    logic        w_word_ready;
    logic [31:0] w_word;
    logic [15:0] w_count_full;
    logic        w_last;

    assign w_ready      = (state_q == ST_LEN0) || (state_q == ST_LEN1) || (state_q == ST_DATA);
    assign w_xfer       = bus.byte_valid && w_ready;
    assign w_start_ok   = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
    assign w_push       = w_xfer && (state_q == ST_DATA);
    assign w_count_full = {bus.byte_data, count_q[7:0]};
    // Index is one bit wider than the address so a full-depth image compares cleanly.
    assign w_last       = (16'(idx_q) == (count_q - 16'd1));

    program_loader_byte_to_word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (w_start_ok),
        .push_i       (w_push),
        .byte_i       (bus.byte_data),
        .word_ready_o (w_word_ready),
        .word_o       (w_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            count_q      <= 16'd0;
            idx_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
            core_reset_q <= 1'b1;
        end else begin
            mem_we_q     <= 1'b0;
            core_reset_q <= (state_q != ST_DONE);
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (bus.start) begin
                        state_q <= ST_LEN0;
                        count_q <= 16'd0;
                        idx_q   <= '0;
                    end
                end
                ST_LEN0: begin
                    if (w_xfer) begin
                        count_q[7:0] <= bus.byte_data;
                        state_q      <= ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    if (w_xfer) begin
                        count_q[15:8] <= bus.byte_data;
                        state_q <= count_in_range(w_count_full, 16'(PROGRAM_MEMORY_SIZE_WORDS))
                                   ? ST_DATA : ST_ERROR;
                    end
                end
                ST_DATA: begin
                    if (w_word_ready) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= idx_q[ADDR_WIDTH-1:0];
                        mem_wdata_q <= w_word;
                        idx_q       <= idx_q + 1'b1;
                        if (w_last) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.byte_ready = w_ready;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.core_reset = core_reset_q;
    assign bus.done       = (state_q == ST_DONE);
    assign bus.error      = (state_q == ST_ERROR);
endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module : tb_program_loader
// Brief  : Randomized self-checking bench for program_loader against a byte-image model
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_program_loader;
    localparam int ADDR_WIDTH = 6;
    localparam int MEM_WORDS  = 64;

    logic clk;
    logic reset;

    program_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) ifc ();

    program_loader #(
        .PROGRAM_MEMORY_SIZE_WORDS (MEM_WORDS),
        .ADDR_WIDTH                (ADDR_WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]            img_b [0:255];
    logic [ADDR_WIDTH-1:0] wr_addr_q [$];
    logic [31:0]           wr_data_q [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Every cycle with mem_we high is one write into the model memory log.
    always @(negedge clk) begin
        if (ifc.mem_we === 1'b1) begin
            wr_addr_q.push_back(ifc.mem_addr);
            wr_data_q.push_back(ifc.mem_wdata);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_pulse();
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int pct, input bit rnd_start);
        int guard;
        while ($urandom_range(99) >= pct) begin
            ifc.byte_valid = 1'b0;
            ifc.start      = rnd_start ? 1'($urandom_range(1)) : 1'b0;
            tick();
        end
        ifc.byte_valid = 1'b1;
        ifc.byte_data  = b;
        ifc.start      = rnd_start ? 1'($urandom_range(1)) : 1'b0;
        guard = 0;
        while (!ifc.byte_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check_val("ready_timeout", 32'(ifc.byte_ready), 32'd1);
        tick();
        ifc.byte_valid = 1'b0;
        ifc.start      = 1'b0;
    endtask

    task automatic send_count(input int cnt);
        logic [15:0] c;
        c = 16'(cnt);
        send_byte(c[7:0], 100, 1'b0);
        send_byte(c[15:8], 100, 1'b0);
    endtask

    task automatic send_words(input int nwords, input int pct, input bit rnd_start);
        for (int i = 0; i < nwords * 4; i++) send_byte(img_b[i], pct, rnd_start);
    endtask

    function automatic logic [31:0] model_word(input int w);
        return 32'(img_b[4*w]) + (32'(img_b[4*w+1]) << 8)
             + (32'(img_b[4*w+2]) << 16) + (32'(img_b[4*w+3]) << 24);
    endfunction

    task automatic check_writes(input string tag, input int n);
        check_val({tag, "_nwr"}, 32'(wr_data_q.size()), 32'(n));
        for (int i = 0; i < wr_data_q.size() && i < n; i++) begin
            check_val({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(i % MEM_WORDS));
            check_val({tag, "_data"}, wr_data_q[i], model_word(i));
        end
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic check_finish(input string tag);
        check_val({tag, "_done"}, 32'(ifc.done), 32'd1);
        check_val({tag, "_err"}, 32'(ifc.error), 32'd0);
        check_val({tag, "_rdy"}, 32'(ifc.byte_ready), 32'd0);
        check_val({tag, "_crst_hold"}, 32'(ifc.core_reset), 32'd1);
        tick();
        check_val({tag, "_crst_low"}, 32'(ifc.core_reset), 32'd0);
    endtask

    task automatic full_load(input string tag, input int cnt, input int pct, input bit rnd_start);
        start_pulse();
        send_count(cnt);
        send_words(cnt, pct, rnd_start);
        check_finish(tag);
        check_writes(tag, cnt);
    endtask

    task automatic expect_error(input string tag, input int cnt);
        start_pulse();
        send_count(cnt);
        check_val({tag, "_err"}, 32'(ifc.error), 32'd1);
        check_val({tag, "_done"}, 32'(ifc.done), 32'd0);
        check_val({tag, "_rdy"}, 32'(ifc.byte_ready), 32'd0);
        repeat (3) tick();
        check_val({tag, "_crst"}, 32'(ifc.core_reset), 32'd1);
        check_writes(tag, 0);
    endtask

    task automatic randomize_image();
        for (int i = 0; i < 256; i++) img_b[i] = 8'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        ifc.start      = 1'b0;
        ifc.byte_valid = 1'b0;
        ifc.byte_data  = 8'h00;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state, stable while idle
        for (int i = 0; i < 10; i++) begin
            check_val("rst_crst", 32'(ifc.core_reset), 32'd1);
            check_val("rst_rdy", 32'(ifc.byte_ready), 32'd0);
            check_val("rst_we", 32'(ifc.mem_we), 32'd0);
            check_val("rst_done", 32'(ifc.done), 32'd0);
            check_val("rst_err", 32'(ifc.error), 32'd0);
            tick();
        end
        check_val("rst_addr", 32'(ifc.mem_addr), 32'd0);
        check_val("rst_wdata", ifc.mem_wdata, 32'd0);

        // Two-word directed image, back-to-back bytes
        img_b[0] = 8'h13; img_b[1] = 8'h05; img_b[2] = 8'hA0; img_b[3] = 8'h00;
        img_b[4] = 8'h6F; img_b[5] = 8'h00; img_b[6] = 8'h00; img_b[7] = 8'h00;
        start_pulse();
        send_count(2);
        send_words(2, 100, 1'b0);
        check_finish("t2");
        check_val("t2_w0", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hDEAD_BEEF, 32'h00A00513);
        check_val("t2_w1", wr_data_q.size() > 1 ? wr_data_q[1] : 32'hDEAD_BEEF, 32'h0000006F);
        check_writes("t2", 2);

        // Bad counts, then recovery
        expect_error("t3_zero", 0);
        expect_error("t3_big", 65);
        randomize_image();
        full_load("t3_recover", 2, 100, 1'b0);

        // Full depth, last address 63 without wrap
        randomize_image();
        start_pulse();
        send_count(64);
        send_words(64, 100, 1'b0);
        check_finish("t4");
        check_val("t4_last_addr", 32'(ifc.mem_addr), 32'd63);
        check_writes("t4", 64);

        // Sparse valid, start ignored while loading
        for (int r = 0; r < 3; r++) begin
            randomize_image();
            full_load("t5", 3, 30, 1'b1);
        end

        // Reset in the middle of word 1
        randomize_image();
        start_pulse();
        send_count(3);
        for (int i = 0; i < 6; i++) send_byte(img_b[i], 100, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check_val("t6_crst", 32'(ifc.core_reset), 32'd1);
        check_val("t6_rdy", 32'(ifc.byte_ready), 32'd0);
        check_val("t6_done", 32'(ifc.done), 32'd0);
        check_writes("t6_partial", 1);
        randomize_image();
        full_load("t6_fresh", 2, 60, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
